sd_card_cmd_responder: RTL

- Card-side end of the SD CMD line: the peer of the host CMD control path.
- Deserializes 48-bit host command frames and checks framing and CRC7.
- Presents index and argument to the card logic, then serializes the 48-bit short or 136-bit long response after an NCR gap.
- Used as the bench responder for the host CMD block and as the card model in system simulation.

---
 rtl/sd_cmd_pkg.sv | 49 ++++
 rtl/sd_card_cmd_responder_if.sv | 32 +++
 rtl/sd_crc7.sv | 29 ++
 rtl/sd_card_cmd_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD line: FSM encodings, CRC7 constants,
// frame lengths and field positions, plus the one-bit CRC7 update step.
// Used by both the card-side responder and the host-side CMD path.
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX       = 3'd1,
    ST_CHECK    = 3'd2,
    ST_NCR_WAIT = 3'd3,
    ST_TX       = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // x^7 + x^3 + 1
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int SHORT_LEN = 48;
  localparam int LONG_LEN  = 136;

  // CRC7 plus end bit close every frame.
  localparam int TAIL_BITS = 8;
  // Start, transmission and 6-bit index/check field open every frame.
  localparam int HDR_BITS  = 8;

  // Positions inside the 47 bits shifted in after the start bit.
  localparam int RX_TX_BIT  = 46;
  localparam int RX_IDX_MSB = 45;
  localparam int RX_IDX_LSB = 40;
  localparam int RX_ARG_MSB = 39;
  localparam int RX_ARG_LSB = 8;
  localparam int RX_CRC_MSB = 7;
  localparam int RX_CRC_LSB = 1;
  localparam int RX_END_BIT = 0;

  // Response request captured when resp_start is accepted.
  typedef struct packed {
    logic         long_resp;
    logic [5:0]   index;
    logic [127:0] data;
  } resp_req_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_card_cmd_responder_if.sv
// CMD-line and card-logic handshake bundle of the SD card responder.
// Ports: receive side (cmd_line_in, cmd_valid/error, index/argument),
// transmit side (cmd_line_out/oe, resp_start/long/index/data, busy/done).
interface sd_card_cmd_responder_if;
  logic         cmd_line_in;
  logic         cmd_line_out;
  logic         cmd_oe;
  logic         cmd_valid;
  logic         cmd_error;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_argument;
  logic         resp_start;
  logic         resp_long;
  logic [5:0]   resp_index;
  logic [127:0] resp_data;
  logic         resp_busy;
  logic         resp_done;

  // Host line plus card logic: drives the line and response requests.
  modport master (
    output cmd_line_in, resp_start, resp_long, resp_index, resp_data,
    input  cmd_line_out, cmd_oe, cmd_valid, cmd_error, cmd_index,
           cmd_argument, resp_busy, resp_done
  );

  // The responder itself.
  modport slave (
    input  cmd_line_in, resp_start, resp_long, resp_index, resp_data,
    output cmd_line_out, cmd_oe, cmd_valid, cmd_error, cmd_index,
           cmd_argument, resp_busy, resp_done
  );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), one bit per enabled cycle, MSB-first.
// Latency: crc reflects a bit on the clock after it is presented; no backpressure.
// Ports: clock, reset (async high), clear, enable, din, crc[6:0].
// clear together with enable restarts from zero and absorbs din in the same
// cycle, so the first bit of a frame can be taken on the detecting edge.
module sd_crc7 import sd_cmd_pkg::*; (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] base;

  always_comb base = clear ? 7'h00 : crc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc <= 7'h00;
    end else if (enable) begin
      crc <= crc7_step(base, din);
    end else if (clear) begin
      crc <= 7'h00;
    end
  end

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line: receives 48-bit commands, sends 48/136-bit responses.
// Latency: cmd_valid/cmd_error 1 cycle after the end bit; response starts NCR cycles after resp_start.
// Backpressure: none; resp_start is taken only in IDLE, ignored otherwise (no queueing).
// Ports: clock, reset (async high), bus (sd_card_cmd_responder_if.slave).
// Build option: CMD_CRC_CHECK_EN also rejects commands whose received CRC7 mismatches.
// NCR must lie in 2..64.
module sd_card_cmd_responder import sd_cmd_pkg::*; #(
  parameter int NCR   = 2,
  parameter int CMD_W = SHORT_LEN
) (
  input  logic                    clock,
  input  logic                    reset,
  sd_card_cmd_responder_if.slave  bus
);

  localparam int RX_CW = $clog2(CMD_W);
  localparam int TX_CW = $clog2(LONG_LEN);

  state_t state, state_nxt;

  // Receive path
  logic [RX_CW-1:0] rx_cnt;
  logic [CMD_W-2:0] rx_sr;
  logic             rx_start;
  logic             rx_crc_clr, rx_crc_en;
  logic [6:0]       rx_crc;
  logic             frame_ok, cmd_good;
  logic [5:0]       index_q;
  logic [31:0]      arg_q;

  // Transmit path
  resp_req_t        req;
  logic             accept;
  logic [TX_CW-1:0] tx_cnt;
  logic [LONG_LEN-1:0] tx_sr;
  logic             tx_long;
  logic             tx_crc_clr, tx_crc_en;
  logic [6:0]       tx_crc;
  logic             tx_bit;

  assign req      = '{long_resp: bus.resp_long, index: bus.resp_index, data: bus.resp_data};
  // resp_start has priority over a start bit arriving in the same cycle.
  assign accept   = (state == ST_IDLE) && bus.resp_start;
  assign rx_start = (state == ST_IDLE) && !bus.resp_start && !bus.cmd_line_in;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept)        state_nxt = ST_NCR_WAIT;
        else if (rx_start) state_nxt = ST_RX;
      end
      ST_RX:       if (rx_cnt == '0) state_nxt = ST_CHECK;
      ST_CHECK:    state_nxt = ST_IDLE;
      ST_NCR_WAIT: if (tx_cnt == '0) state_nxt = ST_TX;
      ST_TX:       if (tx_cnt == '0) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- Receive datapath ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_cnt <= '0;
      rx_sr  <= '0;
    end else if (rx_start) begin
      rx_cnt <= RX_CW'(CMD_W - 2);
      rx_sr  <= '0;
    end else if (state == ST_RX) begin
      rx_sr  <= {rx_sr[CMD_W-3:0], bus.cmd_line_in};
      rx_cnt <= rx_cnt - 1'b1;
    end
  end

  // CRC covers the start bit (taken on the detecting edge) through the
  // last argument bit; rx_cnt >= TAIL_BITS marks the bits before the CRC field.
  assign rx_crc_clr = (state == ST_IDLE);
  assign rx_crc_en  = rx_start || ((state == ST_RX) && (rx_cnt >= RX_CW'(TAIL_BITS)));

  sd_crc7 u_rx_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (rx_crc_clr),
    .enable (rx_crc_en),
    .din    (bus.cmd_line_in),
    .crc    (rx_crc)
  );

  assign frame_ok = rx_sr[RX_TX_BIT] && rx_sr[RX_END_BIT];

`ifdef CMD_CRC_CHECK_EN
  assign cmd_good = frame_ok && (rx_sr[RX_CRC_MSB:RX_CRC_LSB] == rx_crc);
`else
  // Received CRC is not checked in this build; only framing decides.
  logic crc_unused;
  assign crc_unused = ^{rx_sr[RX_CRC_MSB:RX_CRC_LSB], rx_crc};
  assign cmd_good   = frame_ok;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index_q <= '0;
      arg_q   <= '0;
    end else if ((state == ST_CHECK) && cmd_good) begin
      index_q <= rx_sr[RX_IDX_MSB:RX_IDX_LSB];
      arg_q   <= rx_sr[RX_ARG_MSB:RX_ARG_LSB];
    end
  end

  // ---------------- Transmit datapath ----------------
  // tx_cnt doubles as the NCR gap counter and the remaining-bit counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_cnt  <= '0;
      tx_sr   <= '0;
      tx_long <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tx_long <= req.long_resp;
            tx_cnt  <= TX_CW'(NCR - 1);
            // Frame body left-aligned; CRC and end bit are appended on the fly.
            tx_sr   <= req.long_resp ? {2'b00, 6'h3F, req.data[127:8], 8'h00}
                                     : {2'b00, req.index, req.data[31:0], 96'h0};
          end
        end
        ST_NCR_WAIT: begin
          if (tx_cnt == '0) tx_cnt <= tx_long ? TX_CW'(LONG_LEN - 1) : TX_CW'(SHORT_LEN - 1);
          else              tx_cnt <= tx_cnt - 1'b1;
        end
        ST_TX: begin
          if (tx_cnt >= TX_CW'(TAIL_BITS)) tx_sr <= {tx_sr[LONG_LEN-2:0], 1'b0};
          if (tx_cnt != '0)                tx_cnt <= tx_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Long responses exclude the start/transmission/check-bits header from the CRC.
  assign tx_crc_clr = (state == ST_IDLE);
  assign tx_crc_en  = (state == ST_TX) && (tx_cnt >= TX_CW'(TAIL_BITS)) &&
                      (!tx_long || (tx_cnt < TX_CW'(LONG_LEN - HDR_BITS)));

  sd_crc7 u_tx_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (tx_crc_clr),
    .enable (tx_crc_en),
    .din    (tx_sr[LONG_LEN-1]),
    .crc    (tx_crc)
  );

  // Remaining count 7..1 selects crc[6..0]; count 0 is the end bit.
  always_comb begin
    tx_bit = 1'b1;
    if (tx_cnt >= TX_CW'(TAIL_BITS)) tx_bit = tx_sr[LONG_LEN-1];
    else if (tx_cnt != '0)           tx_bit = tx_crc[tx_cnt[2:0] - 3'd1];
  end

  // ---------------- FSM: outputs ----------------
  // Index/argument show the new frame already during CHECK so they are
  // coherent with the cmd_valid pulse; afterwards the held copy is shown.
  always_comb begin
    bus.cmd_line_out = 1'b1;
    bus.cmd_oe       = 1'b0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_error    = 1'b0;
    bus.cmd_index    = index_q;
    bus.cmd_argument = arg_q;
    bus.resp_busy    = 1'b0;
    bus.resp_done    = 1'b0;
    case (state)
      ST_CHECK: begin
        bus.cmd_valid = cmd_good;
        bus.cmd_error = !cmd_good;
        if (cmd_good) begin
          bus.cmd_index    = rx_sr[RX_IDX_MSB:RX_IDX_LSB];
          bus.cmd_argument = rx_sr[RX_ARG_MSB:RX_ARG_LSB];
        end
      end
      ST_NCR_WAIT: bus.resp_busy = 1'b1;
      ST_TX: begin
        bus.resp_busy    = 1'b1;
        bus.cmd_oe       = 1'b1;
        bus.cmd_line_out = tx_bit;
      end
      ST_DONE: bus.resp_done = 1'b1;
      default: ;
    endcase
  end

endmodule
